// File: rtl/nios_system_ocimem_pkg.sv
// Shared types and jdo field positions for the OCI debug-memory controller.
package nios_system_ocimem_pkg;

    typedef enum logic {
        C_IDLE  = 1'b0,
        C_RDATA = 1'b1
    } cpu_state_t;

    localparam int JDO_W         = 38;
    localparam int DATA_W        = 32;
    localparam int BE_W          = DATA_W / 8;
    localparam int JDO_ADDR_LSB  = 17;
    localparam int JDO_RD_BIT    = 34;
    localparam int JDO_WDATA_LSB = 3;

endpackage

// File: rtl/nios_system_nios2_qsys_ocimem_ram.sv
// Single-port monitor RAM: one access per cycle, byte-enabled writes, registered read data.
module nios_system_nios2_qsys_ocimem_ram
    import nios_system_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [BE_W-1:0]   be,
    output logic [DATA_W-1:0] q
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem [DEPTH];

    // q keeps the last read word so consumers may sample it a cycle late.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < BE_W; i++) begin
                    if (be[i]) begin
                        mem[addr][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end else begin
                q <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/nios_system_nios2_qsys_ocimem_ctrl.sv
// OCI RAM controller: JTAG monitor commands and CPU Avalon-MM access share one RAM port, JTAG first.
// Optional CPU write protection is enabled by defining OCIMEM_CPU_WRITE_PROTECT_EN.
module nios_system_nios2_qsys_ocimem_ctrl
    import nios_system_ocimem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic              debugack,
    input  logic [ADDR_W-1:0] avs_address,
    input  logic              avs_read,
    input  logic              avs_write,
    input  logic [31:0]       avs_writedata,
    input  logic [3:0]        avs_byteenable,
    output logic [31:0]       avs_readdata,
    output logic              avs_waitrequest,
    output logic [31:0]       MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              wp_error
);

    cpu_state_t        state;
    logic              jrd_pend;
    logic [31:0]       readdata_hold;

    logic              jtag_a;
    logic              jtag_b;
    logic              jtag_n;
    logic              jtag_any;
    logic [ADDR_W-1:0] jdo_addr;
    logic              jdo_rd;
    logic [31:0]       jdo_wdata;

    logic              cpu_wr_go;
    logic              cpu_rd_go;
    logic              cpu_wr_allowed;

    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [31:0]       ram_wdata;
    logic [3:0]        ram_be;
    logic [31:0]       ram_q;

    logic              unused_jdo;

    assign jdo_addr  = jdo[JDO_ADDR_LSB +: ADDR_W];
    assign jdo_rd    = jdo[JDO_RD_BIT];
    assign jdo_wdata = jdo[JDO_WDATA_LSB +: DATA_W];
    assign unused_jdo = ^{jdo[JDO_WDATA_LSB-1:0], jdo[JDO_W-1:JDO_RD_BIT+1]};

    // Fixed priority between coincident JTAG pulses; losers are simply dropped.
    assign jtag_a   = take_action_ocimem_a;
    assign jtag_b   = take_action_ocimem_b & ~take_action_ocimem_a;
    assign jtag_n   = take_no_action_ocimem_a & ~take_action_ocimem_a & ~take_action_ocimem_b;
    assign jtag_any = jtag_a | jtag_b | jtag_n;

    // A write beats a simultaneous read; CPU only gets the port when JTAG is quiet.
    assign cpu_wr_go = (state == C_IDLE) & avs_write & ~jtag_any;
    assign cpu_rd_go = (state == C_IDLE) & avs_read & ~avs_write & ~jtag_any;

`ifdef OCIMEM_CPU_WRITE_PROTECT_EN
    logic wp_error_q;

    assign cpu_wr_allowed = debugack;
    assign wp_error       = wp_error_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wp_error_q <= 1'b0;
        end else if (cpu_wr_go && !debugack) begin
            wp_error_q <= 1'b1;
        end
    end
`else
    logic unused_debugack;

    assign unused_debugack = debugack;
    assign cpu_wr_allowed  = 1'b1;
    assign wp_error        = 1'b0;
`endif

    always_comb begin
        avs_waitrequest = 1'b0;
        if (state == C_IDLE && (avs_read || avs_write)) begin
            avs_waitrequest = jtag_any | ~avs_write;
        end
    end

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 1'b0;
        ram_addr  = MonAReg;
        ram_wdata = jdo_wdata;
        ram_be    = 4'hF;
        if (jtag_a) begin
            ram_en   = jdo_rd;
            ram_addr = jdo_addr;
        end else if (jtag_b) begin
            ram_en = 1'b1;
            ram_we = 1'b1;
        end else if (jtag_n) begin
            ram_en = 1'b1;
        end else if (cpu_wr_go) begin
            ram_en    = cpu_wr_allowed;
            ram_we    = 1'b1;
            ram_addr  = avs_address;
            ram_wdata = avs_writedata;
            ram_be    = avs_byteenable;
        end else if (cpu_rd_go) begin
            ram_en   = 1'b1;
            ram_addr = avs_address;
        end
    end

    nios_system_nios2_qsys_ocimem_ram #(
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (ram_wdata),
        .be    (ram_be),
        .q     (ram_q)
    );

    // The RAM word is already on ram_q during C_RDATA, so it is forwarded in
    // that cycle and latched for the cycles after.
    assign avs_readdata = (state == C_RDATA) ? ram_q : readdata_hold;

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= C_IDLE;
            jrd_pend      <= 1'b0;
            MonAReg       <= '0;
            MonDReg       <= '0;
            readdata_hold <= '0;
        end else begin
            if (jrd_pend) begin
                MonDReg <= ram_q;
            end
            jrd_pend <= (jtag_a & jdo_rd) | jtag_n;

            if (jtag_a) begin
                MonAReg <= jdo_addr;
            end else if (jtag_b || jtag_n) begin
                MonAReg <= MonAReg + ADDR_W'(1);
            end

            case (state)
                C_IDLE: begin
                    if (cpu_rd_go) begin
                        state <= C_RDATA;
                    end
                end
                C_RDATA: begin
                    readdata_hold <= ram_q;
                    state         <= C_IDLE;
                end
                default: state <= C_IDLE;
            endcase
        end
    end

endmodule
